btb_mem: RTL and testbench
==========================

BTB_MEM -- requirements
Module: btb_mem

Interface
REQ-001 SHALL have port list: DSPCLK  in  1  single clock, all state on posedge.
REQ-002 SHALL have port list: T_RST  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port list: TB_EN  in  1  table enable; low blocks writes and freezes read registers.
REQ-004 SHALL have port list: BTB_ra  in  5  read index, shared by BTB and RTB.
REQ-005 SHALL have port list: BTB_wa  in  5  write index, shared by BTB and RTB.
REQ-006 SHALL have port list: BTB_wd  in  26  write data; BTB entry = {tag[8:0], v, target[13:0], hist[1:0]}.
REQ-007 SHALL have port list: BTB_web  in  1  BTB write strobe, active-low.
REQ-008 SHALL have port list: RTB_web  in  1  RTB write strobe, active-low.
REQ-009 SHALL have port list: BTB_inv  in  1  flush request, one-cycle pulse.
REQ-010 SHALL have port list: BTB_rd  out  26  registered BTB read data.
REQ-011 SHALL have port list: RTB_rd  out  12  registered RTB read data = {tag[8:0], v, hist[1:0]}.
REQ-012 SHALL have port list: BTB_busy  out  1  high while the flush sweep runs.

Function
REQ-013 SHALL hold 32 BTB entries x 26 bits and 32 RTB entries x 12 bits.
REQ-014 SHALL give a one-cycle read: BTB_ra sampled at edge N appears on BTB_rd/RTB_rd after edge N.
REQ-015 SHALL write the BTB on the edge where BTB_web=0, TB_EN=1 and the FSM is IDLE: BTB[BTB_wa] <= BTB_wd.
REQ-016 SHALL write the RTB under the same conditions with RTB_web=0: RTB[BTB_wa] <= {BTB_wd[25:16], BTB_wd[1:0]}; target bits are discarded.
REQ-017 SHALL perform both writes in the same cycle when both strobes are low.
REQ-018 SHALL be read-before-write: a read and a write to the same index in the same cycle returns the old entry; no bypass.
REQ-019 SHALL hold BTB_rd/RTB_rd at their previous value while TB_EN=0.
REQ-020 SHALL implement FSM states IDLE and CLEAR, with a 5-bit sweep counter CNT.
REQ-021 SHALL move IDLE->CLEAR on BTB_inv=1, with CNT <= 0.
REQ-022 SHALL, in CLEAR, write all-zero to BTB[CNT] and RTB[CNT] each cycle, then CNT <= CNT+1.
REQ-023 SHALL move CLEAR->IDLE on the edge that clears CNT=31; wrap to 0 is not used as a condition; total sweep is 32 cycles.
REQ-024 SHALL restart the sweep on BTB_inv=1 during CLEAR: CNT <= 0, stay in CLEAR.
REQ-025 SHALL drive BTB_busy=1 in CLEAR and 0 in IDLE; BTB_busy is a registered state decode.
REQ-026 SHALL, in CLEAR, force BTB_rd and RTB_rd to 0 (v=0, so no hit) and silently drop external writes.
REQ-027 SHALL run the sweep regardless of TB_EN.

Reset
REQ-028 SHALL, on T_RST=1 at an edge: FSM <= CLEAR, CNT <= 0, BTB_rd <= 0, RTB_rd <= 0, BTB_busy <= 1.
REQ-029 SHALL, on T_RST asserted mid-sweep, restart the sweep from index 0.
REQ-030 SHALL give T_RST priority over BTB_inv and over writes.
REQ-031 SHALL not reset the arrays directly; they are cleared only by the sweep.

Configuration
REQ-032 SHALL compile the RTB array and RTB write path in when BTB_RTB_EN is defined.
REQ-033 SHALL, without BTB_RTB_EN, omit the RTB array, tie RTB_rd to 0 and ignore RTB_web; BTB behaviour is unchanged.

Verification
REQ-034 SHALL cover: T_RST pulse -> BTB_busy=1 for 32 cycles, then 0; every index then reads v=0.
REQ-035 SHALL cover: write BTB[5]=26'h2ABCDEF, then BTB_ra=5 -> BTB_rd=26'h2ABCDEF one cycle later.
REQ-036 SHALL cover: same-cycle read and write to index 9 (old 0, new 26'h1) -> BTB_rd=0; the next read gives 26'h1.
REQ-037 SHALL cover: RTB write with BTB_wd=26'h3FFFFFF -> RTB_rd=12'hFFF; with BTB_RTB_EN undefined -> RTB_rd=0.
REQ-038 SHALL cover: BTB_inv at sweep cycle 20 -> BTB_busy stays high for a further 32 cycles; a write during the sweep is lost.
REQ-039 SHALL cover: TB_EN=0 with BTB_web=0 -> the entry is unchanged and BTB_rd holds its last value.

Source files
------------

// File: rtl/btb_mem.sv
// btb_mem: 32-entry branch target buffer with optional return table (BTB_RTB_EN) and sweep flush
module btb_mem (
  input  logic        DSPCLK,
  input  logic        T_RST,
  input  logic        TB_EN,
  input  logic [4:0]  BTB_ra,
  input  logic [4:0]  BTB_wa,
  input  logic [25:0] BTB_wd,
  input  logic        BTB_web,
  input  logic        RTB_web,
  input  logic        BTB_inv,
  output logic [25:0] BTB_rd,
  output logic [11:0] RTB_rd,
  output logic        BTB_busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic [25:0] btb [32];
  logic [25:0] btb_q;
  logic wr_ok;
  assign wr_ok = !T_RST && state == IDLE && TB_EN;
  assign BTB_busy = state == CLEAR;
  assign BTB_rd = BTB_busy ? '0 : btb_q;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (BTB_inv) begin
      state_nx = CLEAR;
      cnt_nx = '0;
    end else if (state == CLEAR) begin
      state_nx = cnt == 5'd31 ? IDLE : CLEAR;
      cnt_nx = cnt + 5'd1;
    end
  end
  always_ff @(posedge DSPCLK) begin
    if (T_RST) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // arrays have no reset; only the sweep clears them
  always_ff @(posedge DSPCLK) begin
    if (!T_RST && state == CLEAR) btb[cnt] <= '0;
    else if (wr_ok && !BTB_web) btb[BTB_wa] <= BTB_wd;
  end
  always_ff @(posedge DSPCLK) begin
    if (T_RST || state == CLEAR) btb_q <= '0;
    else if (TB_EN) btb_q <= btb[BTB_ra];
  end
`ifdef BTB_RTB_EN
  logic [11:0] rtb [32];
  logic [11:0] rtb_q;
  assign RTB_rd = BTB_busy ? '0 : rtb_q;
  always_ff @(posedge DSPCLK) begin
    if (!T_RST && state == CLEAR) rtb[cnt] <= '0;
    else if (wr_ok && !RTB_web) rtb[BTB_wa] <= {BTB_wd[25:16], BTB_wd[1:0]};
  end
  always_ff @(posedge DSPCLK) begin
    if (T_RST || state == CLEAR) rtb_q <= '0;
    else if (TB_EN) rtb_q <= rtb[BTB_ra];
  end
`else
  logic rtb_web_unused;
  assign rtb_web_unused = RTB_web;
  assign RTB_rd = '0;
`endif
endmodule

// File: tb/tb_btb_mem.sv
// tb_btb_mem: scoreboard bench for btb_mem against an array-level reference model
module tb_btb_mem;
  logic        DSPCLK, T_RST, TB_EN, BTB_web, RTB_web, BTB_inv;
  logic [4:0]  BTB_ra, BTB_wa;
  logic [25:0] BTB_wd, BTB_rd;
  logic [11:0] RTB_rd;
  logic        BTB_busy;

  btb_mem dut (
    .DSPCLK(DSPCLK), .T_RST(T_RST), .TB_EN(TB_EN), .BTB_ra(BTB_ra), .BTB_wa(BTB_wa),
    .BTB_wd(BTB_wd), .BTB_web(BTB_web), .RTB_web(RTB_web), .BTB_inv(BTB_inv),
    .BTB_rd(BTB_rd), .RTB_rd(RTB_rd), .BTB_busy(BTB_busy)
  );

  initial DSPCLK = 1'b0;
  always #5 DSPCLK = ~DSPCLK;

  logic [25:0] mb [32];
  logic [11:0] mr [32];
  logic [25:0] erd;
  logic [11:0] err;
  int left;
  logic [38:0] expq [$];
  int total = 0, passed = 0;

  task automatic cyc(input logic rst, en, input logic [4:0] ra, wa,
                     input logic [25:0] wd, input logic bw, rw, inv);
    logic [11:0] rexp;
    T_RST = rst; TB_EN = en; BTB_ra = ra; BTB_wa = wa; BTB_wd = wd;
    BTB_web = bw; RTB_web = rw; BTB_inv = inv;
    @(posedge DSPCLK);
    if (T_RST) begin
      left = 32; erd = '0; err = '0;
    end else if (left > 0) begin
      mb[5'(32 - left)] = '0;
      mr[5'(32 - left)] = '0;
      erd = '0; err = '0;
      left = BTB_inv ? 32 : left - 1;
    end else begin
      if (TB_EN) begin erd = mb[BTB_ra]; err = mr[BTB_ra]; end
      if (TB_EN && !BTB_web) mb[BTB_wa] = BTB_wd;
      if (TB_EN && !RTB_web) mr[BTB_wa] = {BTB_wd[25:16], BTB_wd[1:0]};
      if (BTB_inv) left = 32;
    end
`ifdef BTB_RTB_EN
    rexp = left > 0 ? 12'h0 : err;
`else
    rexp = 12'h0;
`endif
    expq.push_back({left > 0, left > 0 ? 26'h0 : erd, rexp});
    #1;
  endtask

  task automatic idle(input logic [4:0] ra);
    cyc(1'b0, 1'b1, ra, 5'd0, 26'h0, 1'b1, 1'b1, 1'b0);
  endtask

  always @(negedge DSPCLK) begin
    if (expq.size() > 0) begin
      logic [38:0] e;
      e = expq.pop_front();
      total++;
      if ({BTB_busy, BTB_rd, RTB_rd} !== e)
        $display("FAIL out@%0t: got busy=%b btb=%h rtb=%h expected busy=%b btb=%h rtb=%h",
                 $time, BTB_busy, BTB_rd, RTB_rd, e[38], e[37:12], e[11:0]);
      else passed++;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin mb[i] = '0; mr[i] = '0; end
    erd = '0; err = '0; left = 0;
    cyc(1'b1, 1'b1, 5'd0, 5'd0, 26'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 5'd0, 5'd0, 26'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 34; i++) idle(5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i));
    cyc(1'b0, 1'b1, 5'd0, 5'd5, 26'h2ABCDEF, 1'b0, 1'b1, 1'b0);
    idle(5'd5); idle(5'd0);
    cyc(1'b0, 1'b1, 5'd9, 5'd9, 26'h1, 1'b0, 1'b1, 1'b0);
    idle(5'd9); idle(5'd0);
    cyc(1'b0, 1'b1, 5'd0, 5'd12, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0);
    idle(5'd12); idle(5'd0);
    cyc(1'b0, 1'b1, 5'd0, 5'd13, 26'h155AA33, 1'b0, 1'b0, 1'b0);
    idle(5'd13); idle(5'd0);
    idle(5'd5);
    cyc(1'b0, 1'b0, 5'd9, 5'd5, 26'h0000077, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd9, 5'd5, 26'h0000077, 1'b0, 1'b0, 1'b0);
    idle(5'd5); idle(5'd0);
    cyc(1'b0, 1'b1, 5'd5, 5'd0, 26'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) idle(5'd5);
    cyc(1'b0, 1'b1, 5'd5, 5'd3, 26'h0ABCDEF, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 5'd5, 5'd30, 26'h1234567, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 33; i++) idle(5'd3);
    idle(5'd30); idle(5'd0);
    for (int i = 0; i < 20; i++) idle(5'd0);
    cyc(1'b1, 1'b1, 5'd0, 5'd0, 26'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++) idle(5'd0);
    for (int n = 0; n < 700; n++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
          5'($urandom), 5'($urandom), 26'($urandom),
          1'($urandom), 1'($urandom), $urandom_range(0, 79) == 0);
    @(negedge DSPCLK);
    #1;
    total++;
    if (expq.size() != 0) $display("FAIL drain: %0d outputs left unchecked, expected 0", expq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
